fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Program-counter controller and F/D pipeline register that drives the combinational instruction memory of the MIPS core. Each cycle it presents a fetch address to the instruction memory and captures the returned word into the decode stage. It applies stalls, branch/jump redirects (delay slot kept), exception entry and `eret` return with fixed priority. It also counts instructions delivered to decode.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_3000: reset PC and first word of instruction memory.
- `HANDLER_ADDR`, default 32'h0000_4180: exception entry PC.
- `IM_WORDS`, default 4096: instruction memory depth in words, used by the range check.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `stall_i`, in, 1: hazard stall from decode; hold the PC and the F/D register.
- `br_taken_i`, in, 1: branch/jump resolved taken in decode.
- `br_target_i`, in, 32: redirect target.
- `exc_req_i`, in, 1: exception/interrupt accepted by CP0.
- `eret_i`, in, 1: `eret` executing.
- `epc_i`, in, 32: return address for `eret`.
- `im_instr_i`, in, 32: word returned combinationally by instruction memory for `im_pc_o`.
- `im_pc_o`, out, 32: fetch address to instruction memory; equals the PC register.
- `instr_d_o`, out, 32: F/D instruction.
- `pc_d_o`, out, 32: F/D PC.
- `valid_d_o`, out, 1: F/D holds a real fetched instruction.
- `exc_d_o`, out, 1: fetch address error (AdEL) on the F/D instruction.
- `fetch_cnt_o`, out, 32: instructions delivered to decode.

## Operation
The FSM has three states.
- `BOOT`: entered on reset. The PC register holds `BASE_ADDR` and F/D stays invalid. It moves to `RUN` on the first edge after `reset` is released; no PC advance occurs on that edge.
- `RUN`: normal fetch.
- `HOLD`: entered from `RUN` when `stall_i` is high at an edge. It returns to `RUN` on the first edge where `stall_i` is low.

Per-edge priority in `RUN`/`HOLD`, highest first:
1. `exc_req_i`: PC <= `HANDLER_ADDR`; F/D flushed (instr 0, valid 0, exc 0); state -> `RUN`. Overrides the stall.
2. `eret_i`: PC <= `epc_i`; F/D flushed; state -> `RUN`. Overrides the stall.
3. `stall_i`: PC and F/D hold; the branch is ignored, because decode re-presents it; state -> `HOLD`.
4. `br_taken_i`: PC <= `br_target_i`; F/D <= current fetch (delay slot); state `RUN`.
5. Otherwise: PC <= PC + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0); F/D <= current fetch.

Rules for the capture and counter:
- "Current fetch" means instr <= `im_instr_i`, pc <= PC, valid <= 1.
- `fetch_cnt_o` increments by 1 on every edge whose F/D update has valid = 1. It wraps 0xFFFF_FFFF -> 0 and is not flushed.
- In `BOOT`, `exc_req_i`, `eret_i` and the branch inputs are ignored.

## Timing
Reset values: `im_pc_o` = `BASE_ADDR`, `instr_d_o` = 0, `pc_d_o` = 0, `valid_d_o` = 0, `exc_d_o` = 0, `fetch_cnt_o` = 0, state `BOOT`.
- `reset` asserted mid-operation: all of the above take effect immediately (asynchronous), with no wait for `clk`.
- `im_pc_o` → `im_instr_i` is a combinational path within the cycle. Decode sees a word 1 cycle after its address is presented.
- Redirect latency is 1 edge: the target is on `im_pc_o` in the cycle after `br_taken_i`/`exc_req_i`/`eret_i` is sampled high.
- First valid decode instruction: 2nd edge after reset release (BOOT edge, then first fetch edge).

## Configuration
- `FETCH_RANGE_CHECK_EN` defined: on each F/D capture, check whether PC[1:0] ≠ 0 or PC ∉ [`BASE_ADDR`, `BASE_ADDR` + 4·`IM_WORDS`).
  - If so, capture instr = 0 (nop), valid = 1 and `exc_d_o` = 1; otherwise `exc_d_o` = 0.
  - The PC keeps advancing; CP0 is expected to raise `exc_req_i` later.
- Macro undefined: `exc_d_o` is constant 0 and `im_instr_i` is captured unconditionally.

## Structure
- Shared package `mips_fetch_pkg`:
  - FSM state enum (`BOOT`, `RUN`, `HOLD`).
  - Default `BASE_ADDR`/`HANDLER_ADDR` constants.
  - `EXC_ADEL` = 5'd4.
  - `NOP_INSTR` = 32'h0.
- One sub-module, `fetch_range_check`: combinational PC → out-of-range flag. It is instantiated only under `FETCH_RANGE_CHECK_EN`.

## Test plan
- Reset release, no stimulus for 4 edges → `im_pc_o` steps 0x3000, 0x3000, 0x3004, 0x3008, 0x300C. `pc_d_o` = 0x3000 with valid after the 2nd edge. `fetch_cnt_o` = 3.
- `br_taken_i`=1, `br_target_i`=0x3100 while PC=0x3008 → next `im_pc_o` = 0x3100; F/D holds 0x3008 (delay slot) with valid = 1.
- `stall_i` high 3 edges together with `br_taken_i` → PC and F/D frozen and `fetch_cnt_o` unchanged. After the stall releases, the branch is taken once.
- `exc_req_i` and `eret_i` and `br_taken_i` high together, with `stall_i` also high → `im_pc_o` = 0x4180; F/D instr 0, valid 0; state `RUN`.
- `eret_i` with `epc_i` = 0x3020 → `im_pc_o` = 0x3020 next cycle, F/D flushed. Async `reset` mid-cycle then zeroes the outputs without a clock edge.
- With `FETCH_RANGE_CHECK_EN`: `br_target_i` = 0x3002, then 0x7000 → for each, F/D instr 0, `exc_d_o` = 1. Without the macro: `exc_d_o` stays 0.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS fetch stage.
//   fetch_state_e        : fetch sequencer FSM states
//   DEFAULT_BASE_ADDR    : reset PC / first instruction memory word
//   DEFAULT_HANDLER_ADDR : exception entry PC
//   EXC_ADEL             : CP0 exception code for a fetch address error
//   NOP_INSTR            : encoding substituted for a faulting fetch
package mips_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR    = 32'h0000_3000;
    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;
    localparam logic [4:0]  EXC_ADEL             = 5'd4;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;

endpackage

// File: rtl/fetch_range_check.sv
// Combinational fetch-address check.
// Flags a PC that is not word aligned or lies outside the instruction memory
// window [BASE_ADDR, BASE_ADDR + 4*IM_WORDS).
// Ports:
//   pc_i  : fetch address under test
//   bad_o : 1 when the address would raise AdEL
module fetch_range_check #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int unsigned IM_WORDS  = 4096
) (
    input  logic [31:0] pc_i,
    output logic        bad_o
);

    // 33-bit limit so a window ending at 2^32 does not wrap to zero.
    localparam logic [32:0] LOW_LIMIT  = {1'b0, BASE_ADDR};
    localparam logic [32:0] HIGH_LIMIT = {1'b0, BASE_ADDR} + (33'(IM_WORDS) << 2);

    logic [32:0] pc_ext;

    always_comb begin
        pc_ext = {1'b0, pc_i};
        bad_o  = (pc_i[1:0] != 2'b00) || (pc_ext < LOW_LIMIT) || (pc_ext >= HIGH_LIMIT);
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC controller and F/D pipeline register for the MIPS core.
// Presents im_pc_o to a combinational instruction memory each cycle and
// captures the returned word into the decode stage. Redirect priority per
// edge: exception > eret > stall > branch > sequential.
// Optional feature: define FETCH_RANGE_CHECK_EN to flag misaligned or
// out-of-window fetches (captured as a nop with exc_d_o = 1).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   stall_i               : hold PC and F/D
//   br_taken_i/target_i   : taken branch/jump redirect (delay slot kept)
//   exc_req_i             : exception entry to HANDLER_ADDR
//   eret_i/epc_i          : exception return to epc_i
//   im_instr_i / im_pc_o  : instruction memory data / address
//   instr_d_o, pc_d_o, valid_d_o, exc_d_o : F/D register
//   fetch_cnt_o           : count of valid F/D captures
module fetch_sequencer
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR,
    parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
    parameter int unsigned IM_WORDS     = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  logic        exc_req_i,
    input  logic        eret_i,
    input  logic [31:0] epc_i,
    input  logic [31:0] im_instr_i,
    output logic [31:0] im_pc_o,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic        valid_d_o,
    output logic        exc_d_o,
    output logic [31:0] fetch_cnt_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pcd_q, pcd_d;
    logic         valid_q, valid_d;
    logic         exc_q, exc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         capture;
    logic         fetch_bad;

`ifdef FETCH_RANGE_CHECK_EN
    fetch_range_check #(
        .BASE_ADDR (BASE_ADDR),
        .IM_WORDS  (IM_WORDS)
    ) u_range_check (
        .pc_i  (pc_q),
        .bad_o (fetch_bad)
    );
`else
    assign fetch_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pcd_d   = pcd_q;
        valid_d = valid_q;
        exc_d   = exc_q;
        capture = 1'b0;

        unique case (state_q)
            BOOT: begin
                // Redirect inputs are ignored; the PC already holds BASE_ADDR.
                state_d = RUN;
            end
            RUN, HOLD: begin
                if (exc_req_i) begin
                    pc_d    = HANDLER_ADDR;
                    instr_d = NOP_INSTR;
                    pcd_d   = 32'h0;
                    valid_d = 1'b0;
                    exc_d   = 1'b0;
                    state_d = RUN;
                end else if (eret_i) begin
                    pc_d    = epc_i;
                    instr_d = NOP_INSTR;
                    pcd_d   = 32'h0;
                    valid_d = 1'b0;
                    exc_d   = 1'b0;
                    state_d = RUN;
                end else if (stall_i) begin
                    // Decode re-presents any pending branch once the stall clears.
                    state_d = HOLD;
                end else begin
                    capture = 1'b1;
                    pc_d    = br_taken_i ? br_target_i : pc_q + 32'd4;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase

        if (capture) begin
            instr_d = fetch_bad ? NOP_INSTR : im_instr_i;
            pcd_d   = pc_q;
            valid_d = 1'b1;
            exc_d   = fetch_bad;
        end

        cnt_d = capture ? cnt_q + 32'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BOOT;
            pc_q    <= BASE_ADDR;
            instr_q <= NOP_INSTR;
            pcd_q   <= 32'h0;
            valid_q <= 1'b0;
            exc_q   <= 1'b0;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            valid_q <= valid_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign im_pc_o     = pc_q;
    assign instr_d_o   = instr_q;
    assign pc_d_o      = pcd_q;
    assign valid_d_o   = valid_q;
    assign fetch_cnt_o = cnt_q;
`ifdef FETCH_RANGE_CHECK_EN
    assign exc_d_o     = exc_q;
`else
    assign exc_d_o     = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. The instruction memory model returns
// address ^ KEY so every captured word identifies its fetch address.
module tb_fetch_sequencer;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0;
    logic        br_taken_i = 1'b0;
    logic [31:0] br_target_i = 32'h0;
    logic        exc_req_i = 1'b0;
    logic        eret_i = 1'b0;
    logic [31:0] epc_i = 32'h0;
    logic [31:0] im_instr_i;
    logic [31:0] im_pc_o;
    logic [31:0] instr_d_o;
    logic [31:0] pc_d_o;
    logic        valid_d_o;
    logic        exc_d_o;
    logic [31:0] fetch_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign im_instr_i = im_pc_o ^ KEY;

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .stall_i     (stall_i),
        .br_taken_i  (br_taken_i),
        .br_target_i (br_target_i),
        .exc_req_i   (exc_req_i),
        .eret_i      (eret_i),
        .epc_i       (epc_i),
        .im_instr_i  (im_instr_i),
        .im_pc_o     (im_pc_o),
        .instr_d_o   (instr_d_o),
        .pc_d_o      (pc_d_o),
        .valid_d_o   (valid_d_o),
        .exc_d_o     (exc_d_o),
        .fetch_cnt_o (fetch_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare every observable output in one go.
    task automatic expect_all(input string tag, input logic [31:0] pc, input logic [31:0] pcd,
                              input logic [31:0] instr, input logic valid, input logic exc,
                              input logic [31:0] cnt);
        check({tag, ".im_pc"}, im_pc_o, pc);
        check({tag, ".pc_d"}, pc_d_o, pcd);
        check({tag, ".instr_d"}, instr_d_o, instr);
        check({tag, ".valid_d"}, {31'h0, valid_d_o}, {31'h0, valid});
        check({tag, ".exc_d"}, {31'h0, exc_d_o}, {31'h0, exc});
        check({tag, ".cnt"}, fetch_cnt_o, cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic        rc;
    logic [31:0] bad_instr_3002;
    logic [31:0] bad_instr_7000;
    logic [31:0] wrap_instr;

    initial begin
`ifdef FETCH_RANGE_CHECK_EN
        rc = 1'b1;
        bad_instr_3002 = 32'h0;
        bad_instr_7000 = 32'h0;
        wrap_instr     = 32'h0;
`else
        rc = 1'b0;
        bad_instr_3002 = 32'h3002 ^ KEY;
        bad_instr_7000 = 32'h7000 ^ KEY;
        wrap_instr     = 32'hFFFF_FFFC ^ KEY;
`endif

        // Reset state.
        #12;
        expect_all("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        #1 reset = 1'b0;

        // BOOT edge: no advance, F/D still invalid.
        tick();
        expect_all("boot", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        tick();
        expect_all("seq1", 32'h3004, 32'h3000, 32'h3000 ^ KEY, 1'b1, 1'b0, 32'd1);
        tick();
        expect_all("seq2", 32'h3008, 32'h3004, 32'h3004 ^ KEY, 1'b1, 1'b0, 32'd2);

        // Branch at PC 0x3008: delay slot captured, target next.
        br_taken_i = 1'b1; br_target_i = 32'h3100;
        tick();
        expect_all("branch", 32'h3100, 32'h3008, 32'h3008 ^ KEY, 1'b1, 1'b0, 32'd3);
        br_taken_i = 1'b0;
        tick();
        expect_all("after_br", 32'h3104, 32'h3100, 32'h3100 ^ KEY, 1'b1, 1'b0, 32'd4);

        // Stall with a branch pending for 3 edges: everything frozen.
        stall_i = 1'b1; br_taken_i = 1'b1; br_target_i = 32'h3200;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_all("stall", 32'h3104, 32'h3100, 32'h3100 ^ KEY, 1'b1, 1'b0, 32'd4);
        end
        stall_i = 1'b0;
        tick();
        expect_all("stall_rel_br", 32'h3200, 32'h3104, 32'h3104 ^ KEY, 1'b1, 1'b0, 32'd5);
        br_taken_i = 1'b0;
        tick();
        expect_all("br_once", 32'h3204, 32'h3200, 32'h3200 ^ KEY, 1'b1, 1'b0, 32'd6);

        // Exception beats eret, stall and branch.
        exc_req_i = 1'b1; eret_i = 1'b1; epc_i = 32'h3400;
        br_taken_i = 1'b1; br_target_i = 32'h3300; stall_i = 1'b1;
        tick();
        expect_all("exc_prio", 32'h4180, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);
        exc_req_i = 1'b0; eret_i = 1'b0; br_taken_i = 1'b0; stall_i = 1'b0;
        tick();
        expect_all("handler", 32'h4184, 32'h4180, 32'h4180 ^ KEY, 1'b1, 1'b0, 32'd7);

        // eret beats a branch.
        eret_i = 1'b1; epc_i = 32'h3020; br_taken_i = 1'b1; br_target_i = 32'h3300;
        tick();
        expect_all("eret", 32'h3020, 32'h0, 32'h0, 1'b0, 1'b0, 32'd7);
        eret_i = 1'b0; br_taken_i = 1'b0;
        tick();
        expect_all("eret_run", 32'h3024, 32'h3020, 32'h3020 ^ KEY, 1'b1, 1'b0, 32'd8);

        // eret beats a stall.
        eret_i = 1'b1; epc_i = 32'h3040; stall_i = 1'b1;
        tick();
        expect_all("eret_stall", 32'h3040, 32'h0, 32'h0, 1'b0, 1'b0, 32'd8);
        eret_i = 1'b0; stall_i = 1'b0;
        tick();
        expect_all("eret_stall_run", 32'h3044, 32'h3040, 32'h3040 ^ KEY, 1'b1, 1'b0, 32'd9);

        // Asynchronous reset mid-cycle.
        #2 reset = 1'b1;
        #1;
        expect_all("async_rst", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        #2 reset = 1'b0;

        // BOOT ignores redirect requests.
        exc_req_i = 1'b1; eret_i = 1'b1; epc_i = 32'h3400;
        br_taken_i = 1'b1; br_target_i = 32'h3300;
        tick();
        expect_all("boot_ignore", 32'h3000, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
        exc_req_i = 1'b0; eret_i = 1'b0; br_taken_i = 1'b0;
        tick();
        expect_all("boot_fetch", 32'h3004, 32'h3000, 32'h3000 ^ KEY, 1'b1, 1'b0, 32'd1);

        // PC wrap 0xFFFF_FFFC -> 0.
        eret_i = 1'b1; epc_i = 32'hFFFF_FFFC;
        tick();
        check("wrap_pre.im_pc", im_pc_o, 32'hFFFF_FFFC);
        eret_i = 1'b0;
        tick();
        expect_all("wrap", 32'h0, 32'hFFFF_FFFC, wrap_instr, 1'b1, rc, 32'd2);

        // Misaligned and just-past-window fetches, then the last in-window word.
        br_taken_i = 1'b1; br_target_i = 32'h3002;
        tick();
        check("mis_pre.im_pc", im_pc_o, 32'h3002);
        br_target_i = 32'h7000;
        tick();
        expect_all("misaligned", 32'h7000, 32'h3002, bad_instr_3002, 1'b1, rc, 32'd4);
        br_target_i = 32'h6FFC;
        tick();
        expect_all("past_end", 32'h6FFC, 32'h7000, bad_instr_7000, 1'b1, rc, 32'd5);
        br_taken_i = 1'b0;
        tick();
        expect_all("last_word", 32'h7000, 32'h6FFC, 32'h6FFC ^ KEY, 1'b1, 1'b0, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
